spram_burst_ctrl: RTL and testbench
===================================

Name: spram_burst_ctrl

Overview:
- Burst initiator for a single-port block RAM. It drives the RAM's addr/re/we/wdata lines and consumes its read data.
- Accepts one burst command at a time: start address, beat count and direction.
  - Write bursts: data arrives on a valid/ready write stream and goes into RAM.
  - Read bursts: the RAM is read and data is returned on a valid/ready read stream with backpressure.
- Used by cache fill/flush logic in front of each block RAM array.

Parameters:
- ADDR_WIDTH, 4: RAM address width. Must match the attached RAM.
- DATA_WIDTH, 32: RAM word width.
- LEN_WIDTH, 4: width of cmd_len. Burst length is cmd_len+1 beats, so 1..2^LEN_WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller idle, command accepted on cmd_valid&cmd_ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  first beat address
- cmd_len  in  LEN_WIDTH  beats minus one
- wr_valid  in  1  write beat offered
- wr_ready  out  1  write beat accepted
- wr_data  in  DATA_WIDTH  write beat data
- rd_valid  out  1  read beat available
- rd_ready  in  1  read beat consumed
- rd_data  out  DATA_WIDTH  read beat data
- rd_last  out  1  final beat of read burst, qualified by rd_valid
- busy  out  1  state != IDLE
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_re  out  1  RAM read enable
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data. Valid only in the cycle after ram_re, undefined otherwise.

Behaviour:
- Reset: reset is synchronous, active-high, on clk. State goes to IDLE and the output FIFO and in-flight flag are cleared. While reset is high and in the cycle after:
  - cmd_ready=0, wr_ready=0, rd_valid=0, rd_last=0, rd_data=0, busy=0.
  - ram_re=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - Reset mid-burst aborts the burst. Any in-flight RAM read is discarded and never presented.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On accept, latch addr and remaining=cmd_len; go to WRITE if cmd_write else READ.
  - No RAM access in the accept cycle.
- Addressing: address increments by 1 per issued beat, modulo 2^ADDR_WIDTH (0xF wraps to 0x0 at ADDR_WIDTH=4).
- WRITE:
  - wr_ready=1.
  - Combinational: ram_we=wr_valid, ram_addr=cur addr, ram_wdata=wr_data.
  - Each handshake advances addr and decrements remaining.
  - Handshake with remaining==0 returns to IDLE next cycle.
  - ram_re=0 throughout.
- READ issue rules:
  - Output FIFO depth 2. inflight = ram_re registered (1 cycle).
  - ram_re=1 with ram_addr=cur addr when issue_ok: count + inflight - (rd_valid&rd_ready) < 2.
  - Each issue advances addr.
  - Issue of the last beat goes to DRAIN.
- READ capture:
  - In the cycle where inflight=1, ram_rdata is pushed into the FIFO together with a last flag.
  - FIFO head drives rd_data and rd_last. rd_valid = count!=0.
- DRAIN: no new issues. Go to IDLE when inflight=0 and the FIFO is empty after the current pop.
- Latency and throughput:
  - Command accepted in cycle T: first ram_re in T+1, ram_rdata valid in T+2, rd_valid in T+3.
  - With rd_ready held high, one beat per cycle.
  - With rd_ready low, at most 2 beats are buffered and ram_re stops. No beat is lost or duplicated.
- Mutual exclusion: ram_re and ram_we are never high in the same cycle. ram_re is never high outside READ.
- cmd_ready=0 during WRITE, READ and DRAIN. Commands are held off until IDLE.
- rd_data holds its value while rd_valid && !rd_ready.

Optional Feature:
- Macro: SPRAM_BURST_WRAP_EN.
- When defined: wrapping bursts for critical-word-first line fills.
  - cmd_len+1 must be a power of two; other values are undefined behaviour.
  - Address low log2(len+1) bits increment modulo len+1. Upper bits stay fixed at the cmd_addr value.
  - Example: addr 0x6, len 3 gives 0x6, 0x7, 0x4, 0x5.
- When undefined: linear increment modulo 2^ADDR_WIDTH only.

Test Plan:
- Write burst: addr=0x2, len=3, data A0..A3 with wr_valid held high → ram_we high 4 cycles at addrs 2,3,4,5. busy falls after the last beat. cmd_ready back to 1.
- Read back with rd_ready=1: addr=0x2, len=3 → rd_data A0,A1,A2,A3 in consecutive cycles T+3..T+6. rd_last only on A3.
- Backpressure: same read with rd_ready=0 for 5 cycles from T+3 → ram_re issues exactly 2 beats then stops. After release, all 4 beats arrive in order with no duplicates.
- Wrap: linear write at addr=0xE, len=2 → RAM addrs 0xE, 0xF, 0x0.
- Reset mid-read: reset asserted after the 2nd ram_re → outputs zeroed next cycle. A subsequent read of addr 0x2, len 0 returns only A0, with rd_last=1.
- With SPRAM_BURST_WRAP_EN: read addr=0x6, len=3 → ram_addr sequence 6,7,4,5.

Source files
------------

// File: rtl/spram_burst_if.sv
// Bundle of command, write-stream, read-stream and RAM-side signals of spram_burst_ctrl.
// slave = the controller; master = command source, stream endpoints and the attached RAM.
interface spram_burst_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;

  logic                  busy;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_re;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    input  ram_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy,
    output ram_addr, ram_re, ram_we, ram_wdata
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    output ram_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy,
    input  ram_addr, ram_re, ram_we, ram_wdata
  );
endinterface

// File: rtl/spram_burst_ctrl.sv
// Burst initiator for a single-port block RAM: write stream -> RAM, RAM -> read stream.
// Define SPRAM_BURST_WRAP_EN for wrapping (critical-word-first) address sequences.
module spram_burst_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic         clk,
  input  logic         reset,
  spram_burst_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [LEN_WIDTH-1:0]  remaining_reg;
  logic                  reset_q_reg;
  logic                  hold_off;

  logic                  inflight_reg;
  logic                  inflight_last_reg;

  logic [DATA_WIDTH-1:0] fifo_data_reg [2];
  logic                  fifo_last_reg [2];
  logic                  head_reg;
  logic [1:0]            count_reg;
  logic [1:0]            count_next;
  logic                  tail;

  logic                  accept;
  logic                  wr_hs;
  logic                  issue;
  logic                  issue_ok;
  logic                  push;
  logic                  pop;
  logic                  rd_valid_int;
  logic [2:0]            occupancy;

  // Outputs are forced quiet while reset is high and for one cycle after.
  assign hold_off = reset | reset_q_reg;

`ifdef SPRAM_BURST_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_mask_reg;
  logic [ADDR_WIDTH-1:0] cmd_mask;

  // cmd_len is 2^k-1, so it doubles as the mask of address bits that wrap.
  genvar gi;
  for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_mask
    if (gi < LEN_WIDTH) begin : g_bit
      assign cmd_mask[gi] = bus.cmd_len[gi];
    end else begin : g_zero
      assign cmd_mask[gi] = 1'b0;
    end
  end

  assign addr_next = (addr_reg & ~wrap_mask_reg) | ((addr_reg + 1'b1) & wrap_mask_reg);
`else
  assign addr_next = addr_reg + 1'b1;
`endif

  assign accept       = !hold_off && (state_reg == IDLE) && bus.cmd_valid;
  assign wr_hs        = !hold_off && (state_reg == WRITE) && bus.wr_valid;
  assign rd_valid_int = !hold_off && (count_reg != 2'd0);
  assign pop          = rd_valid_int && bus.rd_ready;
  assign push         = inflight_reg;

  // Buffered plus in-flight beats may never exceed the two FIFO slots.
  assign occupancy = 3'(count_reg) + 3'(inflight_reg) - 3'(pop);
  assign issue_ok  = occupancy < 3'd2;
  assign issue     = !hold_off && (state_reg == READ) && issue_ok;

  assign count_next = count_reg + 2'(push) - 2'(pop);
  assign tail       = head_reg ^ count_reg[0];

  always_ff @(posedge clk) begin
    reset_q_reg <= reset;
    if (reset) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      remaining_reg     <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      head_reg          <= 1'b0;
      count_reg         <= 2'd0;
`ifdef SPRAM_BURST_WRAP_EN
      wrap_mask_reg     <= '0;
`endif
    end else begin
      inflight_reg      <= issue;
      inflight_last_reg <= issue && (remaining_reg == '0);

      if (push) begin
        fifo_data_reg[tail] <= bus.ram_rdata;
        fifo_last_reg[tail] <= inflight_last_reg;
      end
      if (pop) begin
        head_reg <= ~head_reg;
      end
      count_reg <= count_next;

      case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg      <= bus.cmd_addr;
            remaining_reg <= bus.cmd_len;
`ifdef SPRAM_BURST_WRAP_EN
            wrap_mask_reg <= cmd_mask;
`endif
            state_reg     <= bus.cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_hs) begin
            addr_reg      <= addr_next;
            remaining_reg <= remaining_reg - 1'b1;
            if (remaining_reg == '0) begin
              state_reg <= IDLE;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr_reg      <= addr_next;
            remaining_reg <= remaining_reg - 1'b1;
            if (remaining_reg == '0) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!inflight_reg && (count_next == 2'd0)) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = !hold_off && (state_reg == IDLE);
  assign bus.busy      = !hold_off && (state_reg != IDLE);
  assign bus.wr_ready  = !hold_off && (state_reg == WRITE);

  assign bus.ram_we    = wr_hs;
  assign bus.ram_re    = issue;
  assign bus.ram_addr  = (!hold_off && (state_reg == WRITE || state_reg == READ)) ? addr_reg : '0;
  assign bus.ram_wdata = (!hold_off && (state_reg == WRITE)) ? bus.wr_data : '0;

  assign bus.rd_valid  = rd_valid_int;
  assign bus.rd_data   = rd_valid_int ? fifo_data_reg[head_reg] : '0;
  assign bus.rd_last   = rd_valid_int && fifo_last_reg[head_reg];

endmodule

// File: tb/tb_spram_burst_ctrl.sv
// Self-checking bench for spram_burst_ctrl: RAM model, burst-level scoreboard and directed bursts.
module tb_spram_burst_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spram_burst_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .LEN_WIDTH(4)) bus ();

  spram_burst_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .LEN_WIDTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Attached RAM: one-cycle registered read, garbage when not read.
  logic [31:0] ram_mem [16] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= bus.ram_re ? ram_mem[bus.ram_addr] : (32'hDEAD_0000 | 32'(cyc));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Address of beat i in a burst, from the addressing rules.
  function automatic logic [3:0] model_addr(input logic [3:0] base, input int len, input int i);
`ifdef SPRAM_BURST_WRAP_EN
    int span = len + 1;
    int b = int'(base);
    return 4'((b - (b % span)) + ((b % span) + i) % span);
`else
    return 4'((int'(base) + i) % 16);
`endif
  endfunction

  // Scoreboard state and per-test logs.
  logic [31:0] shadow [16] = '{default: 32'h0};
  logic [3:0]  exp_waddr [$];
  logic [3:0]  exp_raddr [$];
  logic [31:0] exp_rdata [$];
  logic        exp_rlast [$];
  logic [3:0]  wlog [$];
  logic [3:0]  relog [$];
  logic [31:0] rlog_data [$];
  logic        rlog_last [$];
  int          rlog_cyc [$];
  int          accept_cyc = 0;
  int          outstanding = 0;
  logic        prev_reset = 1'b1;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_rd_data = 32'h0;

  always @(negedge clk) begin
    if (reset || prev_reset) begin
      check("rst_ctrl_outputs", {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_last,
                                 bus.busy, bus.ram_re, bus.ram_we}, 64'h0);
      check("rst_rd_data", bus.rd_data, 64'h0);
      check("rst_ram_bus", {bus.ram_wdata, bus.ram_addr}, 64'h0);
      exp_waddr.delete(); exp_raddr.delete(); exp_rdata.delete(); exp_rlast.delete();
      outstanding = 0;
      prev_stall = 1'b0;
    end else begin
      check("mutex_re_we", bus.ram_re & bus.ram_we, 64'h0);
      check("ready_vs_busy", bus.cmd_ready, !bus.busy);
      check("read_outstanding_le2", outstanding <= 2, 64'h1);
      if (prev_stall) begin
        check("stall_hold_valid", bus.rd_valid, 64'h1);
        check("stall_hold_data", bus.rd_data, prev_rd_data);
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        accept_cyc = cyc;
        for (int i = 0; i <= int'(bus.cmd_len); i++) begin
          logic [3:0] a;
          a = model_addr(bus.cmd_addr, int'(bus.cmd_len), i);
          if (bus.cmd_write) exp_waddr.push_back(a);
          else begin
            exp_raddr.push_back(a);
            exp_rdata.push_back(shadow[a]);
            exp_rlast.push_back(i == int'(bus.cmd_len));
          end
        end
      end
      check("we_is_handshake", bus.ram_we, bus.wr_valid && bus.wr_ready);
      if (bus.ram_we) begin
        if (exp_waddr.size() == 0) check("ram_we_unexpected", bus.ram_we, 64'h0);
        else begin
          logic [3:0] e;
          e = exp_waddr.pop_front();
          check("wr_addr", bus.ram_addr, e);
          check("wr_wdata", bus.ram_wdata, bus.wr_data);
          shadow[e] = bus.wr_data;
        end
        wlog.push_back(bus.ram_addr);
      end
      if (bus.ram_re) begin
        if (exp_raddr.size() == 0) check("ram_re_unexpected", bus.ram_re, 64'h0);
        else check("rd_issue_addr", bus.ram_addr, exp_raddr.pop_front());
        relog.push_back(bus.ram_addr);
        outstanding++;
      end
      if (bus.rd_valid && bus.rd_ready) begin
        if (exp_rdata.size() == 0) check("rd_beat_unexpected", bus.rd_valid && bus.rd_ready, 64'h0);
        else begin
          check("rd_data", bus.rd_data, exp_rdata.pop_front());
          check("rd_last", bus.rd_last, exp_rlast.pop_front());
        end
        rlog_data.push_back(bus.rd_data);
        rlog_last.push_back(bus.rd_last);
        rlog_cyc.push_back(cyc);
        outstanding--;
      end
      prev_stall   = bus.rd_valid && !bus.rd_ready;
      prev_rd_data = bus.rd_data;
    end
    prev_reset = reset;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wlog.delete(); relog.delete(); rlog_data.delete(); rlog_last.delete(); rlog_cyc.delete();
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!bus.cmd_ready && n < limit) begin
      step();
      n++;
    end
    if (!bus.cmd_ready) check("idle_timeout", bus.cmd_ready, 64'h1);
  endtask

  task automatic send_cmd(input logic w, input logic [3:0] a, input logic [3:0] l);
    wait_idle(50);
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic write_beat(input logic [31:0] d);
    int n = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    while (!bus.wr_ready && n < 20) begin
      step();
      n++;
    end
    if (!bus.wr_ready) check("wr_ready_timeout", bus.wr_ready, 64'h1);
    step();
  endtask

  task automatic check_read_a0_a3(input string tag);
    check({tag, "_beats"}, rlog_data.size(), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rlog_data.size()) begin
        check({tag, "_data_lit"}, rlog_data[i], 32'hA0 + 32'(i));
        check({tag, "_last_lit"}, rlog_last[i], i == 3);
      end
    end
  endtask

  initial begin
    automatic logic [3:0] exp_w1 [4];
    automatic int t;
`ifdef SPRAM_BURST_WRAP_EN
    exp_w1 = '{4'h2, 4'h3, 4'h0, 4'h1};
`else
    exp_w1 = '{4'h2, 4'h3, 4'h4, 4'h5};
`endif
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("after_reset_cmd_ready", bus.cmd_ready, 64'h0);
    step();
    check("idle_cmd_ready", bus.cmd_ready, 64'h1);

    // Write burst A0..A3 at 0x2.
    clear_logs();
    send_cmd(1'b1, 4'h2, 4'd3);
    for (int i = 0; i < 4; i++) write_beat(32'hA0 + 32'(i));
    bus.wr_valid = 1'b0;
    check("wr_done_busy", bus.busy, 64'h0);
    check("wr_done_cmd_ready", bus.cmd_ready, 64'h1);
    check("wr_beats", wlog.size(), 64'd4);
    for (int i = 0; i < 4; i++) if (i < wlog.size()) check("wr_addr_lit", wlog[i], exp_w1[i]);
    $display("txn write addr=2 len=3 beats=%0d", wlog.size());

    // Read back with rd_ready held high: beats at T+3..T+6.
    clear_logs();
    bus.rd_ready = 1'b1;
    send_cmd(1'b0, 4'h2, 4'd3);
    t = accept_cyc;
    wait_idle(40);
    check_read_a0_a3("rd");
    for (int i = 0; i < 4; i++) if (i < rlog_cyc.size()) check("rd_latency", rlog_cyc[i], 64'(t + 3 + i));
    $display("txn read addr=2 len=3 beats=%0d", rlog_data.size());

    // Backpressure: rd_ready low for cycles T+3..T+7.
    clear_logs();
    bus.rd_ready = 1'b0;
    send_cmd(1'b0, 4'h2, 4'd3);
    repeat (7) step();
    check("bp_issue_count", relog.size(), 64'd2);
    check("bp_no_beats", rlog_data.size(), 64'd0);
    bus.rd_ready = 1'b1;
    wait_idle(40);
    check_read_a0_a3("bp");
    $display("txn read_bp addr=2 len=3 beats=%0d", rlog_data.size());

`ifdef SPRAM_BURST_WRAP_EN
    // Wrapping read: 6,7,4,5.
    clear_logs();
    send_cmd(1'b0, 4'h6, 4'd3);
    wait_idle(40);
    check("wrap_issue_count", relog.size(), 64'd4);
    for (int i = 0; i < 4; i++) begin
      automatic logic [3:0] wexp [4] = '{4'h6, 4'h7, 4'h4, 4'h5};
      if (i < relog.size()) check("wrap_addr_lit", relog[i], wexp[i]);
    end
    $display("txn read_wrap addr=6 len=3 beats=%0d", rlog_data.size());
`else
    // Linear write across the top of the address space.
    clear_logs();
    send_cmd(1'b1, 4'hE, 4'd2);
    for (int i = 0; i < 3; i++) write_beat(32'hB0 + 32'(i));
    bus.wr_valid = 1'b0;
    check("wrap_beats", wlog.size(), 64'd3);
    for (int i = 0; i < 3; i++) begin
      automatic logic [3:0] wexp [3] = '{4'hE, 4'hF, 4'h0};
      if (i < wlog.size()) check("wrap_addr_lit", wlog[i], wexp[i]);
    end
    $display("txn write addr=e len=2 beats=%0d", wlog.size());
`endif

    // Reset after the second issue of a read.
    clear_logs();
    bus.rd_ready = 1'b1;
    send_cmd(1'b0, 4'h2, 4'd3);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("rst_mid_issues", relog.size(), 64'd2);
    check("rst_mid_no_beats", rlog_data.size(), 64'd0);
    $display("txn read_reset addr=2 len=3 issues=%0d beats=%0d", relog.size(), rlog_data.size());

    clear_logs();
    send_cmd(1'b0, 4'h2, 4'd0);
    wait_idle(40);
    check("single_beats", rlog_data.size(), 64'd1);
    if (rlog_data.size() > 0) begin
      check("single_data_lit", rlog_data[0], 32'hA0);
      check("single_last_lit", rlog_last[0], 64'h1);
    end
    $display("txn read addr=2 len=0 beats=%0d", rlog_data.size());

    repeat (3) step();
    check("left_expected_reads", exp_rdata.size(), 64'd0);
    check("left_expected_writes", exp_waddr.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
